// File: rtl/mask_gen.sv
// Per-pixel mask generator: OR of up to four rectangular windows with optional inversion.
// Window settings go to shadow registers and are committed at start-of-frame.
module mask_gen #(
  parameter int NWIN = 4,
  parameter int W    = 10
) (
  input  logic         iCLK,
  input  logic         iRST_N,
  input  logic         iEN,
  input  logic [W-1:0] iDVI_X,
  input  logic [W-1:0] iDVI_Y,
  input  logic         iDVI_VAL,
  input  logic         iCFG_WE,
  input  logic [4:0]   iCFG_ADDR,
  input  logic [W-1:0] iCFG_DATA,
  output logic         oMASK,
  output logic         oMASK_VAL,
  output logic [W-1:0] oMASK_X,
  output logic [W-1:0] oMASK_Y,
  output logic [7:0]   oFRAME_CNT,
  output logic         oBUSY
);

  localparam int NREG = 4 * NWIN;

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE} state_t;

  state_t state, stateNext;

  logic [W-1:0]    shReg [NREG];
  logic [W-1:0]    shRegNext [NREG];
  logic [W-1:0]    actReg [NREG];
  logic [W-1:0]    useReg [NREG];
  logic [NWIN-1:0] shWinEn, shWinEnNext, actWinEn, useWinEn;
  logic            shInv, shInvNext, actInv, useInv;

  logic sofP0, commitP0, emitP0, maskP0, hitAnyP0;

  // Inclusive unsigned window test; an inverted range never hits.
  function automatic logic winHit(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic [W-1:0] x0, input logic [W-1:0] x1,
                                  input logic [W-1:0] y0, input logic [W-1:0] y1);
    return (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
  endfunction

  assign sofP0    = iDVI_VAL && (iDVI_X == '0) && (iDVI_Y == '0);
  assign commitP0 = iEN && sofP0 && ((state == WAIT_SOF) || (state == ACTIVE));
  assign emitP0   = iEN && (((state == WAIT_SOF) && sofP0) ||
                            ((state == ACTIVE) && iDVI_VAL));
  assign oBUSY    = (state != IDLE);

  // Shadow image including this cycle's write, so a write on the SOF cycle joins the commit.
  always_comb begin
    for (int k = 0; k < NREG; k++) begin
      shRegNext[k] = (iCFG_WE && (iCFG_ADDR == 5'(k))) ? iCFG_DATA : shReg[k];
    end
    shWinEnNext = shWinEn;
    shInvNext   = shInv;
    if (iCFG_WE && (iCFG_ADDR == 5'd16)) begin
      shWinEnNext = iCFG_DATA[NWIN-1:0];
      shInvNext   = iCFG_DATA[NWIN];
    end
  end

  always_comb begin
    useReg   = commitP0 ? shRegNext : actReg;
    useWinEn = commitP0 ? shWinEnNext : actWinEn;
    useInv   = commitP0 ? shInvNext : actInv;
    hitAnyP0 = 1'b0;
    for (int i = 0; i < NWIN; i++) begin
      if (useWinEn[i] && winHit(iDVI_X, iDVI_Y, useReg[4*i], useReg[4*i+1],
                                useReg[4*i+2], useReg[4*i+3]))
        hitAnyP0 = 1'b1;
    end
    maskP0 = hitAnyP0 ^ useInv;
  end

  always_comb begin
    stateNext = state;
    if (!iEN) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE:     stateNext = WAIT_SOF;
        WAIT_SOF: if (sofP0) stateNext = ACTIVE;
        ACTIVE:   stateNext = ACTIVE;
        default:  stateNext = IDLE;
      endcase
    end
  end

  // Stage p0 -> outputs: one register stage from sampled DVI inputs.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= IDLE;
      oMASK      <= 1'b0;
      oMASK_VAL  <= 1'b0;
      oMASK_X    <= '0;
      oMASK_Y    <= '0;
      oFRAME_CNT <= '0;
      shWinEn    <= '0;
      shInv      <= 1'b0;
      actWinEn   <= '0;
      actInv     <= 1'b0;
      for (int k = 0; k < NREG; k++) begin
        shReg[k]  <= '0;
        actReg[k] <= '0;
      end
    end else begin
      state     <= stateNext;
      oMASK_VAL <= emitP0;
      if (emitP0) begin
        oMASK   <= maskP0;
        oMASK_X <= iDVI_X;
        oMASK_Y <= iDVI_Y;
      end
      if ((state == IDLE) && iEN)
        oFRAME_CNT <= '0;
      else if (commitP0)
        oFRAME_CNT <= oFRAME_CNT + 8'd1;
      shReg   <= shRegNext;
      shWinEn <= shWinEnNext;
      shInv   <= shInvNext;
      if (commitP0) begin
        actReg   <= shRegNext;
        actWinEn <= shWinEnNext;
        actInv   <= shInvNext;
      end
    end
  end

endmodule

// File: tb/tb_mask_gen.sv
// Bench for mask_gen: directed test-plan steps plus random frames, checked against a
// behavioural model of windows, shadow/active configuration and frame bookkeeping.
module tb_mask_gen;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic       iEN = 1'b0;
  logic [9:0] iDVI_X = '0, iDVI_Y = '0;
  logic       iDVI_VAL = 1'b0;
  logic       iCFG_WE = 1'b0;
  logic [4:0] iCFG_ADDR = '0;
  logic [9:0] iCFG_DATA = '0;
  logic       oMASK, oMASK_VAL, oBUSY;
  logic [9:0] oMASK_X, oMASK_Y;
  logic [7:0] oFRAME_CNT;

  int checks = 0;
  int errors = 0;

  // Reference model
  int  sCoord [16], aCoord [16];
  int  sEn, aEn, sInv, aInv;
  bit  running, framing;
  int  eCnt, eX, eY, eMask, eVal;

  mask_gen #(.NWIN(4), .W(10)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iEN(iEN),
    .iDVI_X(iDVI_X), .iDVI_Y(iDVI_Y), .iDVI_VAL(iDVI_VAL),
    .iCFG_WE(iCFG_WE), .iCFG_ADDR(iCFG_ADDR), .iCFG_DATA(iCFG_DATA),
    .oMASK(oMASK), .oMASK_VAL(oMASK_VAL), .oMASK_X(oMASK_X), .oMASK_Y(oMASK_Y),
    .oFRAME_CNT(oFRAME_CNT), .oBUSY(oBUSY)
  );

  always #5 iCLK = ~iCLK;

  task automatic modelReset();
    for (int k = 0; k < 16; k++) begin sCoord[k] = 0; aCoord[k] = 0; end
    sEn = 0; aEn = 0; sInv = 0; aInv = 0;
    running = 0; framing = 0;
    eCnt = 0; eX = 0; eY = 0; eMask = 0; eVal = 0;
  endtask

  function automatic int refMask(input int x, input int y);
    int hit = 0;
    for (int w = 0; w < 4; w++)
      if (((aEn >> w) & 1) == 1 &&
          x >= aCoord[4*w] && x <= aCoord[4*w+1] &&
          y >= aCoord[4*w+2] && y <= aCoord[4*w+3])
        hit = 1;
    return hit ^ aInv;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkAll(input string tag);
    chk({tag, ".val"},   int'(oMASK_VAL),  eVal);
    chk({tag, ".mask"},  int'(oMASK),      eMask);
    chk({tag, ".x"},     int'(oMASK_X),    eX);
    chk({tag, ".y"},     int'(oMASK_Y),    eY);
    chk({tag, ".cnt"},   int'(oFRAME_CNT), eCnt);
    chk({tag, ".busy"},  int'(oBUSY),      int'(running));
  endtask

  // One clock: drive inputs, advance the model, check just after the edge.
  task automatic cyc(input string tag, input int x, input int y, input bit val,
                     input bit we, input int addr, input int data);
    bit sof, emit, commit;
    iDVI_X = 10'(x); iDVI_Y = 10'(y); iDVI_VAL = val;
    iCFG_WE = we; iCFG_ADDR = 5'(addr); iCFG_DATA = 10'(data);
    sof = val && x == 0 && y == 0;
    emit = 0; commit = 0;
    if (we && addr < 16) sCoord[addr] = data;
    if (we && addr == 16) begin sEn = data % 16; sInv = (data / 16) % 2; end
    if (!iEN) begin
      running = 0; framing = 0;
    end else if (!running) begin
      running = 1; framing = 0; eCnt = 0;
    end else if (!framing) begin
      if (sof) begin commit = 1; emit = 1; framing = 1; end
    end else begin
      emit = val; commit = sof;
    end
    if (commit) begin
      for (int k = 0; k < 16; k++) aCoord[k] = sCoord[k];
      aEn = sEn; aInv = sInv;
      eCnt = (eCnt + 1) % 256;
    end
    eVal = emit;
    if (emit) begin eX = x; eY = y; eMask = refMask(x, y); end
    @(posedge iCLK);
    #1;
    chkAll(tag);
  endtask

  task automatic idleCyc(input string tag, input bit we, input int addr, input int data);
    cyc(tag, int'($urandom_range(0, 1023)), int'($urandom_range(1, 1023)), 1'b0, we, addr, data);
  endtask

  // 4x4 raster; optional invalid gap after each pixel and one config write at pixel wrIdx.
  task automatic frame(input string tag, input bit gaps, input int wrIdx,
                       input int addr, input int data);
    for (int p = 0; p < 16; p++) begin
      cyc(tag, p % 4, p / 4, 1'b1, p == wrIdx, addr, data);
      if (gaps) idleCyc({tag, ".gap"}, 1'b0, 0, 0);
    end
  endtask

  task automatic cfgWin(input int w, input int x0, input int x1, input int y0, input int y1);
    idleCyc("cfg", 1'b1, 4*w,   x0);
    idleCyc("cfg", 1'b1, 4*w+1, x1);
    idleCyc("cfg", 1'b1, 4*w+2, y0);
    idleCyc("cfg", 1'b1, 4*w+3, y1);
  endtask

  initial begin
    modelReset();
    #12;
    chkAll("reset");
    iRST_N = 1'b1;
    @(posedge iCLK); #1;

    // 1: no configuration, mask stays 0, one frame counted
    iEN = 1'b1;
    idleCyc("t1.arm", 1'b0, 0, 0);
    idleCyc("t1.wait", 1'b0, 0, 0);
    frame("t1", 1'b0, -1, 0, 0);
    chk("t1.frames", int'(oFRAME_CNT), 1);

    // 2: single window, then inverted
    cfgWin(0, 1, 2, 1, 2);
    idleCyc("t2.ctl", 1'b1, 16, 5'b00001);
    frame("t2", 1'b0, -1, 0, 0);
    idleCyc("t2.inv", 1'b1, 16, 5'b10001);
    frame("t2i", 1'b0, -1, 0, 0);
    idleCyc("t2.noinv", 1'b1, 16, 5'b00001);

    // 3: mid-frame write held to next frame; write on SOF applies at once
    frame("t3a", 1'b0, 9, 1, 3);
    frame("t3b", 1'b0, -1, 0, 0);
    frame("t3c", 1'b0, 0, 1, 1);
    cyc("t3.ign", 0, 3, 1'b1, 1'b1, 17, 1023);

    // 4: empty window alone, then overlapping windows 0 and 2
    cfgWin(1, 5, 3, 0, 3);
    idleCyc("t4.ctl", 1'b1, 16, 5'b00010);
    frame("t4a", 1'b0, -1, 0, 0);
    cfgWin(0, 0, 2, 0, 2);
    cfgWin(2, 1, 3, 1, 3);
    idleCyc("t4.ctl2", 1'b1, 16, 5'b00101);
    frame("t4b", 1'b0, -1, 0, 0);

    // 5: alternate valid gaps
    frame("t5", 1'b1, -1, 0, 0);

    // 6: disable mid-frame, re-enable mid-frame, then async reset mid-frame
    for (int p = 0; p < 6; p++) cyc("t6.pre", p % 4, p / 4, 1'b1, 1'b0, 0, 0);
    iEN = 1'b0;
    cyc("t6.off", 2, 1, 1'b1, 1'b0, 0, 0);
    cyc("t6.idle", 3, 1, 1'b1, 1'b0, 0, 0);
    iEN = 1'b1;
    for (int p = 8; p < 16; p++) cyc("t6.re", p % 4, p / 4, 1'b1, 1'b0, 0, 0);
    frame("t6f", 1'b0, -1, 0, 0);
    chk("t6.frames", int'(oFRAME_CNT), 1);
    for (int p = 0; p < 6; p++) cyc("t6.mid", p % 4, p / 4, 1'b1, 1'b0, 0, 0);
    #2 iRST_N = 1'b0;
    #1;
    modelReset();
    chkAll("t6.arst");
    @(posedge iCLK); #1;
    iRST_N = 1'b1;
    idleCyc("t6.arm", 1'b0, 0, 0);
    frame("t6post", 1'b0, -1, 0, 0);

    // Random windows, gaps, stray pixels and in-frame writes
    for (int f = 0; f < 12; f++) begin
      for (int n = 0; n < 3; n++)
        idleCyc("rnd.cfg", 1'b1, int'($urandom_range(0, 16)), int'($urandom_range(0, 31)));
      for (int p = 0; p < 16; p++) begin
        int wa = int'($urandom_range(0, 20));
        cyc("rnd", p % 4, p / 4, 1'b1, wa <= 16, wa, int'($urandom_range(0, 5)));
        if ($urandom_range(0, 2) == 0)
          cyc("rnd.px", int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
              1'(($urandom_range(0, 1))), 1'b0, 0, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
